fft_sample_loader: RTL and testbench

//  Input stage of the FFT datapath. Accepts a byte stream over the rts/rtr handshake and pairs
//  the bytes into complex samples (real byte first, then imaginary byte). Each sample is

---
 rtl/fft_sample_loader_pkg.sv | 17 +
 rtl/fft_sample_loader_if.sv | 30 +++
 rtl/fft_sample_loader_addr_bitrev.sv | 17 +
 rtl/fft_sample_loader.sv | 100 ++++++++++
 tb/tb_fft_sample_loader.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_sample_loader_pkg.sv
// Shared constants for the FFT sample loader: default widths, FSM state encoding
// and the complex sample type handed to the butterfly engine.
package fft_sample_loader_pkg;

  localparam int FFT_DATA_W = 8;
  localparam int FFT_N_LOG2 = 5;

  localparam logic [1:0] ST_LOAD_RE = 2'd0;
  localparam logic [1:0] ST_LOAD_IM = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  typedef struct packed {
    logic [FFT_DATA_W-1:0] re;
    logic [FFT_DATA_W-1:0] im;
  } sample_t;

endpackage

// File: rtl/fft_sample_loader_if.sv
// Byte-stream input, sample RAM write port and frame status of the FFT sample loader.
// The loader uses the slave modport; the upstream source and engine side use master.
interface fft_sample_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);

  logic [DATA_W-1:0] in_data;
  logic              in_rts;
  logic              in_rtr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_re;
  logic [DATA_W-1:0] wr_im;
  logic              frame_ready;
  logic              frame_ack;
  logic              full;
  logic [ADDR_W-1:0] sample_idx;

  modport slave (
    input  in_data, in_rts, frame_ack,
    output in_rtr, wr_en, wr_addr, wr_re, wr_im, frame_ready, full, sample_idx
  );

  modport master (
    output in_data, in_rts, frame_ack,
    input  in_rtr, wr_en, wr_addr, wr_re, wr_im, frame_ready, full, sample_idx
  );

endinterface

// File: rtl/fft_sample_loader_addr_bitrev.sv
// Combinational W-bit address reverser; maps natural sample order to
// decimation-in-time input order.
module addr_bitrev #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_addr,
  output logic [W-1:0] o_addr
);

  always_comb begin
    o_addr = '0;
    for (int b = 0; b < W; b++) begin
      o_addr[b] = i_addr[W-1-b];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Pairs an rts/rtr byte stream into complex samples and writes one frame to the sample RAM.
// Build option FFT_LOADER_BITREV_EN stores the frame at bit-reversed addresses.
module fft_sample_loader
  import fft_sample_loader_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_LOG2 = FFT_N_LOG2,
  localparam int ADDR_W = N_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  fft_sample_loader_if.slave  bus
);

  localparam logic [N_LOG2:0] LAST_IDX = {1'b0, {N_LOG2{1'b1}}};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [N_LOG2:0]   r_idx;
  logic              r_rtr;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_re_hold;
  logic [DATA_W-1:0] r_wr_re;
  logic [DATA_W-1:0] r_wr_im;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              w_xfer;
  logic              w_wr_take;

  assign w_xfer    = bus.in_rts && r_rtr;
  assign w_wr_take = (r_state == ST_LOAD_IM) && w_xfer;

`ifdef FFT_LOADER_BITREV_EN
  addr_bitrev #(.W(N_LOG2)) u_addr_bitrev (
    .i_addr (r_idx[N_LOG2-1:0]),
    .o_addr (w_addr)
  );
`else
  assign w_addr = r_idx[N_LOG2-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD_RE: if (w_xfer) w_state_nxt = ST_LOAD_IM;
      ST_LOAD_IM: if (w_xfer) w_state_nxt = (r_idx == LAST_IDX) ? ST_HOLD : ST_LOAD_RE;
      ST_HOLD:    if (bus.frame_ack) w_state_nxt = ST_LOAD_RE;
      default:    w_state_nxt = ST_LOAD_RE;
    endcase
  end

  // Control stage: FSM, handshake, sample counter, write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD_RE;
      r_rtr   <= 1'b0;
      r_idx   <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rtr   <= (w_state_nxt != ST_HOLD);
      r_wr_en <= w_wr_take;
      if ((r_state == ST_HOLD) && bus.frame_ack) begin
        r_idx <= '0;
      end else if (w_wr_take) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Real byte is parked until its imaginary partner arrives; a reset abandons it
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOAD_RE) && w_xfer) begin
      r_re_hold <= bus.in_data;
    end
  end

  // Write stage: RAM port registers, updated only with a completed sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr <= '0;
      r_wr_re   <= '0;
      r_wr_im   <= '0;
    end else if (w_wr_take) begin
      r_wr_addr <= w_addr;
      r_wr_re   <= r_re_hold;
      r_wr_im   <= bus.in_data;
    end
  end

  assign bus.in_rtr      = r_rtr;
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_re       = r_wr_re;
  assign bus.wr_im       = r_wr_im;
  assign bus.frame_ready = (r_state == ST_HOLD);
  assign bus.full        = (r_state == ST_HOLD);
  assign bus.sample_idx  = r_idx[ADDR_W-1:0];

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: byte-counting reference model checked every
// cycle, plus literal checks on the captured RAM write log.
module tb_fft_sample_loader;
  import fft_sample_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fft_sample_loader_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  fft_sample_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int addr;
    int re;
    int im;
    int fr;
    int cyc;
  } wr_t;
  wr_t wlog[$];

`ifdef FFT_LOADER_BITREV_EN
  localparam int EXP_ADDR_S1 = 16;
  localparam int EXP_ADDR_S6 = 12;
`else
  localparam int EXP_ADDR_S1 = 1;
  localparam int EXP_ADDR_S6 = 6;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int k);
    int r;
    r = k;
`ifdef FFT_LOADER_BITREV_EN
    r = 0;
    for (int b = 0; b < 5; b++) begin
      if (k[b]) r = r | (1 << (4 - b));
    end
`endif
    return r;
  endfunction

  // Reference model: bytes accepted in the current frame and whether the frame is parked
  int          m_nb    = 0;
  bit          m_hold  = 0;
  bit          m_valid = 0;
  logic        m_rtr   = 1'b0;
  logic        m_wr_en = 1'b0;
  logic [7:0]  m_re    = '0;
  logic [4:0]  m_addr  = '0;
  logic [7:0]  m_wre   = '0;
  logic [7:0]  m_wim   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_rtr",      bus.in_rtr,      m_rtr);
      chk("wr_en",       bus.wr_en,       m_wr_en);
      chk("wr_addr",     bus.wr_addr,     m_addr);
      chk("wr_re",       bus.wr_re,       m_wre);
      chk("wr_im",       bus.wr_im,       m_wim);
      chk("frame_ready", bus.frame_ready, m_hold);
      chk("full",        bus.full,        m_hold);
      chk("sample_idx",  bus.sample_idx,  (m_nb / 2) % 32);
    end
    if (bus.wr_en === 1'b1)
      wlog.push_back('{int'(bus.wr_addr), int'(bus.wr_re), int'(bus.wr_im),
                       int'(bus.frame_ready), cyc});
    if (reset) begin
      m_nb = 0; m_hold = 0; m_rtr = 1'b0; m_wr_en = 1'b0;
      m_addr = '0; m_wre = '0; m_wim = '0;
    end else begin
      m_wr_en = 1'b0;
      if (m_hold) begin
        if (bus.frame_ack) begin
          m_hold = 0;
          m_nb   = 0;
        end
      end else if (bus.in_rts && m_rtr) begin
        if (m_nb % 2 == 0) begin
          m_re = bus.in_data;
        end else begin
          m_wr_en = 1'b1;
          m_addr  = 5'(addr_of(m_nb / 2));
          m_wre   = m_re;
          m_wim   = bus.in_data;
        end
        m_nb++;
        if (m_nb == 64) m_hold = 1;
      end
      m_rtr = !m_hold;
    end
    m_valid = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present bytes base, base+1, ...; with gap>0 in_rts toggles every gap cycles
  task automatic feed(input int nbytes, input int gap, input logic [7:0] base);
    int sent = 0;
    int n = 0;
    logic xf;
    while (sent < nbytes && n < 800) begin
      bus.in_rts  = (gap == 0) ? 1'b1 : (((n / gap) % 2) == 0);
      bus.in_data = base + 8'(sent);
      xf = bus.in_rts && bus.in_rtr;
      tick();
      n++;
      if (xf) sent++;
    end
    bus.in_rts = 1'b0;
    if (sent < nbytes) chk("feed_timeout", sent, nbytes);
  endtask

  task automatic check_frame(input string tag, input bit back_to_back);
    chk({tag, "_count"}, wlog.size(), 32);
    if (wlog.size() == 32) begin
      for (int k = 0; k < 32; k++) begin
        chk({tag, "_addr"}, wlog[k].addr, addr_of(k));
        chk({tag, "_re"},   wlog[k].re,   2 * k);
        chk({tag, "_im"},   wlog[k].im,   2 * k + 1);
        if (k > 0) begin
          if (back_to_back) chk({tag, "_spacing"}, wlog[k].cyc - wlog[k-1].cyc, 2);
          else              chk({tag, "_gap"}, (wlog[k].cyc - wlog[k-1].cyc) >= 2, 1);
        end
      end
      chk({tag, "_ready_at_last"}, wlog[31].fr, 1);
      chk({tag, "_ready_before"},  wlog[30].fr, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.in_rts    = 1'b0;
    bus.in_data   = '0;
    bus.frame_ack = 1'b0;

    // Reset held 10 cycles
    repeat (10) tick();
    chk("rst_rtr",   bus.in_rtr, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_ready", bus.frame_ready, 0);
    chk("rst_idx",   bus.sample_idx, 0);
    chk("rst_data",  {bus.wr_addr, bus.wr_re, bus.wr_im}, 0);
    reset = 1'b0;
    tick();
    chk("rtr_after_rst", bus.in_rtr, 1);

    // Full frame, in_rts continuously high, bytes 0x00..0x3F
    wlog.delete();
    feed(64, 0, 8'h00);
    bus.in_rts = 1'b1;
    repeat (20) tick();
    bus.in_rts = 1'b0;
    check_frame("frame", 1'b1);
    if (wlog.size() == 32) begin
      chk("s1_addr", wlog[1].addr, EXP_ADDR_S1);
      chk("s1_re",   wlog[1].re, 8'h02);
      chk("s1_im",   wlog[1].im, 8'h03);
      chk("s6_addr", wlog[6].addr, EXP_ADDR_S6);
      chk("s6_re",   wlog[6].re, 8'h0C);
      chk("s6_im",   wlog[6].im, 8'h0D);
    end
    chk("hold_rtr",   bus.in_rtr, 0);
    chk("hold_ready", bus.frame_ready, 1);
    chk("hold_full",  bus.full, 1);

    // Acknowledge the frame, then the next byte is a real part
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("ack_ready", bus.frame_ready, 0);
    chk("ack_idx",   bus.sample_idx, 0);
    chk("ack_rtr",   bus.in_rtr, 1);
    wlog.delete();
    feed(2, 0, 8'hA1);
    tick();
    chk("post_ack_writes", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("post_ack_addr", wlog[0].addr, 0);
      chk("post_ack_re",   wlog[0].re, 8'hA1);
      chk("post_ack_im",   wlog[0].im, 8'hA2);
    end

    // frame_ack while loading has no effect
    bus.frame_ack = 1'b1;
    repeat (2) tick();
    bus.frame_ack = 1'b0;
    chk("load_ack_idx",   bus.sample_idx, 1);
    chk("load_ack_ready", bus.frame_ready, 0);

    // Reset after 3 samples plus one real byte of a frame
    feed(5, 0, 8'h10);
    repeat (2) tick();
    chk("pre_rst_writes", wlog.size(), 3);
    chk("pre_rst_idx",    bus.sample_idx, 3);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("mid_rst_writes", wlog.size(), 3);
    chk("mid_rst_idx",    bus.sample_idx, 0);

    // Gapped in_rts must give the same RAM image
    wlog.delete();
    feed(64, 5, 8'h00);
    repeat (3) tick();
    check_frame("gapped", 1'b0);
    if (wlog.size() > 0) chk("gapped_first_addr", wlog[0].addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
